// File: rtl/se_relu_arbiter.sv
// Round-robin arbiter sharing one ReLU/saturation unit among the FC1 accumulator lanes.
// Results are tagged with their source lane. Credit-based issue keeps the output FIFO from overflowing.
module se_relu_arbiter #(
  parameter int unsigned INT_BITS   = 5,
  parameter int unsigned FRAC_BITS  = 9,
  parameter int unsigned DATA_WIDTH = INT_BITS + FRAC_BITS,
  parameter int unsigned IN_WIDTH   = 2 * DATA_WIDTH - FRAC_BITS + 6,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data,
  output logic                          relu_en,
  output logic [IN_WIDTH-1:0]           relu_din,
  input  logic [DATA_WIDTH-1:0]         relu_dout,
  input  logic                          relu_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  input  logic                          sat_clr,
  output logic [15:0]                   sat_cnt,
  output logic                          err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] SatVal = {1'b0, {(DATA_WIDTH - 1){1'b1}}};

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [ID_W-1:0]       tag_q, tag_d;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [15:0]           sat_cnt_q, sat_cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [ID_W-1:0]       mem_id_q   [DEPTH];

  logic            push, pop, credit_ok, gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic [CntW:0]   occ;
  int unsigned     cand;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = relu_valid & inflight_q;

  // Occupancy counts the in-flight result too, so a grant always has a FIFO slot waiting.
  assign occ       = {1'b0, fifo_cnt_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
  assign credit_ok = occ < (CntW + 1)'(DEPTH);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = 0;
    if (!rst && credit_ok) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = (32'(rr_ptr_q) + i) % NUM_REQ;
        if (!gnt_valid && req_valid[cand[ID_W-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_id    = cand[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    relu_en   = gnt_valid;
    relu_din  = '0;
    if (gnt_valid) begin
      req_ready[gnt_id] = 1'b1;
      relu_din          = req_data[32'(gnt_id) * IN_WIDTH +: IN_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    inflight_d = gnt_valid;
    tag_d      = tag_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sat_cnt_d  = sat_cnt_q;
    err_d      = err_q;
    if (gnt_valid) begin
      rr_ptr_d = (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
      tag_d    = gnt_id;
    end
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    if (relu_valid && !inflight_q) err_d = 1'b1;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (push && relu_dout == SatVal && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sat_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sat_cnt_q  <= sat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible while fifo_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= relu_dout;
      mem_id_q[wr_ptr_q]   <= tag_q;
    end
  end

  assign out_data = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_id   = out_valid ? mem_id_q[rd_ptr_q] : '0;
  assign sat_cnt  = sat_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_se_relu_arbiter.sv
// Directed bench for se_relu_arbiter with a behavioural ReLU unit and an output scoreboard.
module tb_se_relu_arbiter;

  localparam int unsigned IW = 25;
  localparam int unsigned DW = 14;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [4*IW-1:0] req_data;
  logic            relu_en;
  logic [IW-1:0]   relu_din;
  logic [DW-1:0]   relu_dout;
  logic            relu_valid;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            sat_clr;
  logic [15:0]     sat_cnt;
  logic            err;

  logic [IW-1:0]   lane_d [4];
  logic            force_rv;
  exp_t            sb [$];
  exp_t            e;
  int              checks = 0;
  int              errors = 0;
  int              grants;

  se_relu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .relu_en    (relu_en),
    .relu_din   (relu_din),
    .relu_dout  (relu_dout),
    .relu_valid (relu_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .sat_clr    (sat_clr),
    .sat_cnt    (sat_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < 4; i++) req_data[i*IW +: IW] = lane_d[i];
  end

  function automatic logic [DW-1:0] relu_f(input logic [IW-1:0] x);
    if (x[IW-1]) return '0;
    if (x > 25'h0001FFF) return 14'h1FFF;
    return x[DW-1:0];
  endfunction

  // Registered ReLU model; force_rv injects a spurious valid.
  always @(posedge clk) begin
    if (rst) begin
      relu_valid <= 1'b0;
      relu_dout  <= '0;
    end else begin
      relu_valid <= relu_en | force_rv;
      relu_dout  <= relu_f(relu_din);
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got id=%0d data=%h, required no output", out_id, out_data);
      end else begin
        e = sb.pop_front();
        if (out_id !== e.id || out_data !== e.data) begin
          errors++;
          $display("FAIL sb_out: got id=%0d data=%h, required id=%0d data=%h",
                   out_id, out_data, e.id, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [1:0] id, input logic [DW-1:0] data);
    exp_t x;
    x.id   = id;
    x.data = data;
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b1; sat_clr = 1'b0; force_rv = 1'b0;
    for (int i = 0; i < 4; i++) lane_d[i] = IW'((i + 1) * 32'h100);

    // Reset with random requests: everything at reset values.
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'($urandom);
      tick();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_relu_en", 32'(relu_en), 0);
      chk("rst_relu_din", 32'(relu_din), 0);
      chk("rst_out", {out_valid, out_id, out_data, err}, 0);
      chk("rst_sat_cnt", 32'(sat_cnt), 0);
    end
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("first_grant", 32'(req_ready), 32'b0010);
    chk("first_din", 32'(relu_din), 32'h200);
    expect_out(2'd1, 14'h0200);
    tick();
    req_valid = '0;
    wait_drain();

    // Lane 2 alone: latency T -> T+2.
    req_valid = 4'b0100;
    #1;
    chk("l2_ready", 32'(req_ready), 32'b0100);
    expect_out(2'd2, 14'h0300);
    tick();
    req_valid = '0;
    chk("l2_t1_out_valid", 32'(out_valid), 0);
    tick();
    chk("l2_t2_out", {out_valid, out_id, out_data}, {1'b1, 2'd2, 14'h0300});
    wait_drain();

    // All lanes valid from a fresh pointer: 0,1,2,3,0,1 without bubbles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      expect_out(2'(k % 4), 14'((k % 4 + 1) * 32'h100));
      tick();
    end
    req_valid = '0;
    wait_drain();

    // ReLU clamp and saturation counting on lane 0.
    req_valid = 4'b0001;
    lane_d[0] = 25'h1FFFE00;
    expect_out(2'd0, 14'h0000);
    expect_out(2'd0, 14'h1E00);
    expect_out(2'd0, 14'h1FFF);
    #1; chk("neg_ready", 32'(req_ready), 1); tick();
    lane_d[0] = 25'h0001E00;
    #1; chk("mid_ready", 32'(req_ready), 1); tick();
    lane_d[0] = 25'h0002800;
    #1; chk("sat_ready", 32'(req_ready), 1); tick();
    req_valid = '0;
    lane_d[0] = 25'h0000100;
    wait_drain();
    chk("sat_cnt_one", 32'(sat_cnt), 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_cnt_clr", 32'(sat_cnt), 0);

    // Backpressure: credit admits exactly two grants (pointer now at lane 1).
    out_ready = 1'b0;
    req_valid = 4'b1111;
    grants = 0;
    expect_out(2'd1, 14'h0200);
    expect_out(2'd2, 14'h0300);
    for (int c = 0; c < 6; c++) begin
      #1;
      grants += $countones(req_ready);
      tick();
    end
    #1;
    chk("stall_grants", 32'(grants), 2);
    chk("stall_ready_zero", 32'(req_ready), 0);
    chk("stall_head", {out_valid, out_id, out_data}, {1'b1, 2'd1, 14'h0200});
    req_valid = 4'b1000;
    out_ready = 1'b1;
    #1;
    chk("resume_grant", 32'(req_ready), 32'b1000);
    expect_out(2'd3, 14'h0400);
    tick();
    req_valid = '0;
    wait_drain();

    // Spurious relu_valid sets the sticky error without pushing.
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    tick();
    chk("err_sticky", 32'(err), 1);
    chk("err_no_push", 32'(out_valid), 0);

    // Reset with a result in flight and FIFO occupied.
    out_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_err", 32'(err), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("midrst_lane0", 32'(req_ready), 32'b0001);
    expect_out(2'd0, 14'h0100);
    tick();
    req_valid = '0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
